// File: rtl/fp_adder_arbiter.sv
// fp_adder_arbiter: round-robin sharing of one combinational FP adder among N_REQ requesters
// through a two-stage operand/result pipeline with valid/ready on requests and responses.
module fp_adder_arbiter #(
   parameter int N_REQ = 4,
   parameter int IDW   = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [32*N_REQ-1:0]   req_a,
   input  logic [32*N_REQ-1:0]   req_b,
   output logic [N_REQ-1:0]      req_ready,
   output logic [31:0]           add_a,
   output logic [31:0]           add_b,
   input  logic [31:0]           add_out,
   input  logic                  add_ovf,
   output logic [N_REQ-1:0]      rsp_valid,
   output logic [31:0]           rsp_data,
   output logic                  rsp_ovf,
   input  logic [N_REQ-1:0]      rsp_ready,
   output logic [15:0]           ops_done
);
   logic           s1_valid, s2_valid, s2_ovf, found, adv1, adv2, accept;
   logic [IDW-1:0] s1_id, s2_id, last, grant;
   logic [31:0]    s1_a, s1_b, s2_data;

   assign adv2      = !s2_valid || rsp_ready[s2_id];
   assign adv1      = !s1_valid || adv2;
   assign req_ready = (adv1 && found && rst_n) ? N_REQ'(1) << grant : '0;
   assign accept    = |(req_valid & req_ready);
   assign add_a     = s1_a;
   assign add_b     = s1_b;
   assign rsp_valid = s2_valid ? N_REQ'(1) << s2_id : '0;
   assign rsp_data  = s2_data;
   assign rsp_ovf   = s2_ovf;

   // first valid requester after the last one served, wrapping round
   always_comb begin
      found = 1'b0;
      grant = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         if (!found && req_valid[(int'(last) + k) % N_REQ]) begin
            found = 1'b1;
            grant = IDW'((int'(last) + k) % N_REQ);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_id    <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
         s2_valid <= 1'b0;
         s2_id    <= '0;
         s2_data  <= '0;
         s2_ovf   <= 1'b0;
         last     <= IDW'(N_REQ - 1);
         ops_done <= '0;
      end else begin
         if (adv1) begin
            s1_valid <= accept;
            if (accept) begin
               s1_id <= grant;
               s1_a  <= req_a[32*int'(grant) +: 32];
               s1_b  <= req_b[32*int'(grant) +: 32];
               last  <= grant;
            end
         end
         if (adv2) begin
            s2_valid <= s1_valid;
            s2_id    <= s1_id;
            s2_data  <= add_out;
            s2_ovf   <= add_ovf;
         end
         if (|(rsp_valid & rsp_ready))
            ops_done <= ops_done + 16'd1;
      end
   end
endmodule

// File: tb/tb_fp_adder_arbiter.sv
// tb_fp_adder_arbiter: randomized and directed bench for fp_adder_arbiter against a queue-based
// model of arbitration order, in-order responses and the completion counter.
module tb_fp_adder_arbiter;
   localparam int N = 4;

   logic            clk = 1'b0, rst_n = 1'b0;
   logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
   logic [32*N-1:0] req_a, req_b;
   logic [31:0]     add_a, add_b, add_out, rsp_data;
   logic            add_ovf, rsp_ovf;
   logic [15:0]     ops_done;

   logic [N-1:0]    v = '0, rr = '0;
   logic [31:0]     a [N], b [N];

   typedef struct {int id; logic [31:0] d; logic o; longint vis;} op_t;
   op_t         q [$];
   longint      e = 0;
   int          last_m = N - 1;
   logic [15:0] ops_m = '0;
   int          n_chk = 0, n_pass = 0;

   fp_adder_arbiter #(.N_REQ(N), .IDW(2)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .add_a(add_a), .add_b(add_b), .add_out(add_out), .add_ovf(add_ovf),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ovf(rsp_ovf), .rsp_ready(rsp_ready),
      .ops_done(ops_done)
   );

   always #5 clk = ~clk;

   assign req_valid = v;
   assign rsp_ready = rr;
   for (genvar g = 0; g < N; g++) begin : pk
      assign req_a[32*g +: 32] = a[g];
      assign req_b[32*g +: 32] = b[g];
   end

   // positive-operand FP add with truncation; inf operand or exponent overflow flags ovf
   function automatic logic [32:0] fadd(input logic [31:0] x, input logic [31:0] y);
      logic [31:0] t;
      logic [7:0]  er;
      logic [24:0] ms;
      if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) return {1'b1, 32'h7F800000};
      if (y[30:23] > x[30:23]) begin t = x; x = y; y = t; end
      ms = {2'b01, x[22:0]} + ({2'b01, y[22:0]} >> (x[30:23] - y[30:23]));
      er = x[30:23];
      if (ms[24]) begin ms = ms >> 1; er = er + 8'd1; end
      if (er == 8'hFF) return {1'b1, 32'h7F800000};
      return {1'b0, 1'b0, er, ms[22:0]};
   endfunction

   always_comb {add_ovf, add_out} = fadd(add_a, add_b);

   function automatic logic [31:0] rnd();
      if ($urandom_range(15) == 0) return 32'h7F800000;
      return {1'b0, 8'($urandom_range(254, 1)), 23'($urandom)};
   endfunction

   function automatic int inflight(input int i);
      int c = 0;
      foreach (q[k]) if (q[k].id == i) c++;
      return c;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic model_reset();
      q.delete();
      last_m = N - 1;
      ops_m  = '0;
      e      = 0;
   endtask

   task automatic drive(input int p_valid, input int p_ready);
      for (int i = 0; i < N; i++) begin
         if (!v[i] && inflight(i) < 2 && $urandom_range(99) < p_valid) begin
            v[i] = 1'b1;
            a[i] = rnd();
            b[i] = rnd();
         end
         rr[i] = $urandom_range(99) < p_ready;
      end
   endtask

   // check outputs for the current cycle, then advance the model and the clock by one edge
   task automatic tick();
      logic [N-1:0] exp_rv, exp_rr;
      logic [31:0]  d;
      logic         o, any, pop;
      int           g = 0, acc = -1;
      op_t          h;
      #3;
      exp_rv = (q.size() > 0 && e >= q[0].vis) ? N'(1) << q[0].id : '0;
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (exp_rv != 0) begin
         chk("rsp_data", rsp_data, q[0].d);
         chk("rsp_ovf", 32'(rsp_ovf), 32'(q[0].o));
      end
      chk("ops_done", 32'(ops_done), 32'(ops_m));
      any = 1'b0;
      for (int k = 1; k <= N; k++)
         if (!any && v[(last_m + k) % N]) begin any = 1'b1; g = (last_m + k) % N; end
      pop    = exp_rv != 0 && rr[q[0].id];
      exp_rr = ((q.size() < 2 || pop) && any) ? N'(1) << g : '0;
      chk("req_ready", 32'(req_ready), 32'(exp_rr));
      if (pop) begin
         void'(q.pop_front());
         ops_m++;
         if (q.size() > 0) begin
            h = q[0];
            if (h.vis < e + 1) h.vis = e + 1;
            q[0] = h;
         end
      end
      if (exp_rr != 0) begin
         {o, d} = fadd(a[g], b[g]);
         q.push_back('{id: g, d: d, o: o, vis: e + 2});
         last_m = g;
         acc = g;
      end
      @(posedge clk);
      #1;
      e++;
      if (acc >= 0) v[acc] = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin a[i] = '0; b[i] = '0; end
      v = '1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_ops_done", 32'(ops_done), 32'h0);
      v = '0;
      rst_n = 1'b1;
      model_reset();
      // single op
      v[0] = 1'b1; a[0] = 32'h3F800000; b[0] = 32'h40000000; rr = '1;
      tick();
      tick();
      chk("single_rv", 32'(rsp_valid), 32'h1);
      chk("single_data", rsp_data, 32'h40400000);
      chk("single_ovf", 32'(rsp_ovf), 32'h0);
      tick();
      chk("single_ops", 32'(ops_done), 32'h1);
      // round robin with everyone always valid; last served was 0
      for (int n = 0; n < 12; n++) begin
         drive(100, 100);
         #1;
         chk("rr_grant", 32'(req_ready), 32'(N'(1) << ((n + 1) % N)));
         tick();
      end
      repeat (6) begin drive(0, 100); tick(); end
      // backpressure on requester 1
      rr = 4'b1101;
      v[1] = 1'b1; a[1] = rnd(); b[1] = rnd();
      tick();
      v[2] = 1'b1; a[2] = rnd(); b[2] = rnd();
      tick();
      v[3] = 1'b1; a[3] = rnd(); b[3] = rnd();
      repeat (5) begin
         #1;
         chk("bp_ready", 32'(req_ready), 32'h0);
         chk("bp_data", rsp_data, q[0].d);
         tick();
      end
      rr = '1;
      repeat (6) tick();
      chk("bp_drained", 32'(q.size()), 32'h0);
      // overflow
      v[0] = 1'b1; a[0] = 32'h7F800000; b[0] = 32'h3F800000;
      tick();
      tick();
      chk("ovf_data", rsp_data, 32'h7F800000);
      chk("ovf_flag", 32'(rsp_ovf), 32'h1);
      tick();
      // random traffic
      repeat (2000) begin drive(60, 70); tick(); end
      repeat (12) begin drive(0, 100); tick(); end
      // reset with both stages full
      rr = '0;
      v[0] = 1'b1; a[0] = rnd(); b[0] = rnd();
      tick();
      v[1] = 1'b1; a[1] = rnd(); b[1] = rnd();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("midrst_ops_done", 32'(ops_done), 32'h0);
      chk("midrst_req_ready", 32'(req_ready), 32'h0);
      v = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      rr = '1;
      drive(100, 100);
      #1;
      chk("postrst_first", 32'(req_ready), 32'h1);
      tick();
      // counter wrap
      for (int n = 0; n < 70000 && ops_m != 16'hFFFF; n++) begin drive(100, 100); tick(); end
      chk("wrap_ffff", 32'(ops_done), 32'h0000FFFF);
      for (int n = 0; n < 10 && ops_m != 16'h0000; n++) begin drive(100, 100); tick(); end
      chk("wrap_zero", 32'(ops_done), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
